// File: rtl/pattern_burst_unit_pkg.sv
// Shared definitions for pattern_burst_unit: state encoding and the
// enable bundle passed from the controller to the datapath.
package pattern_burst_unit_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_DETECT  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_LOAD    = 3'd4;
  localparam logic [2:0] ST_COUNT   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_INIT    = ST_INIT,
    S_DETECT  = ST_DETECT,
    S_CAPTURE = ST_CAPTURE,
    S_LOAD    = ST_LOAD,
    S_COUNT   = ST_COUNT
  } state_e;

  typedef struct packed {
    logic pat_shift;
    logic pat_clr;
    logic cap_shift;
    logic cap_clr;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_clr;
  } dp_ctrl_t;

endpackage

// File: rtl/pattern_burst_unit_ctrl.sv
// pbu_ctrl: frame sequencing FSM; decodes the registered state into status
// pulses and datapath enables.
module pbu_ctrl
  import pattern_burst_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  logic     abort,
  input  logic     cont,
  input  logic     match,
  input  logic     last_bit,
  input  logic     cnt_zero,
  output dp_ctrl_t ctl,
  output logic     ready,
  output logic     busy,
  output logic     det,
  output logic     w_out,
  output logic     done
);

  state_e state_q;
  state_e state_d;

  // Next-state, status pulses and datapath enables
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    det     = 1'b0;
    w_out   = 1'b0;
    done    = 1'b0;
    ready   = (state_q == S_IDLE);
    busy    = (state_q != S_IDLE);
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_INIT;
          else       state_d = S_IDLE;
        end
        S_INIT: begin
          ctl.pat_clr = 1'b1;
          ctl.cap_clr = 1'b1;
          if (start) state_d = S_INIT;
          else       state_d = S_DETECT;
        end
        S_DETECT: begin
          ctl.pat_shift = 1'b1;
          if (match) begin
            det     = 1'b1;
            state_d = S_CAPTURE;
          end else begin
            state_d = S_DETECT;
          end
        end
        S_CAPTURE: begin
          ctl.cap_shift = 1'b1;
          if (last_bit) state_d = S_LOAD;
          else          state_d = S_CAPTURE;
        end
        S_LOAD: begin
          ctl.cnt_load = 1'b1;
          state_d      = S_COUNT;
        end
        S_COUNT: begin
          if (!cnt_zero) begin
            w_out       = 1'b1;
            ctl.cnt_dec = 1'b1;
            state_d     = S_COUNT;
          end else begin
            done        = 1'b1;
            ctl.pat_clr = 1'b1;
            if (cont) state_d = S_DETECT;
            else      state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // The counter is zeroed on every path into IDLE, including abort.
    ctl.cnt_clr = (state_d == S_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/pattern_burst_unit.sv
// pattern_burst_unit: sync-pattern hunt, serial payload capture and a
// payload-length w_out window driven by a down counter.
module pattern_burst_unit
  import pattern_burst_unit_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic              ser_in,
  output logic              ready,
  output logic              busy,
  output logic              det,
  output logic              w_out,
  output logic              done,
  output logic [DATA_W-1:0] cnt_val
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_GATE = FILL_W'(PAT_W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  // Only PAT_W-1 history bits are stored; the live ser_in completes the window.
  logic [PAT_W-2:0]  pat_q,  pat_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [BIT_W-1:0]  bit_q,  bit_d;
  logic [DATA_W-1:0] pay_q,  pay_d;
  logic [DATA_W-1:0] cnt_q,  cnt_d;

  logic [PAT_W-1:0] window_s;
  logic             match_s;
  logic             last_bit_s;
  logic             cnt_zero_s;
  dp_ctrl_t         ctl_s;

  assign window_s   = {pat_q, ser_in};
  assign match_s    = (fill_q >= FILL_GATE) && (window_s == PATTERN);
  assign last_bit_s = (bit_q == BIT_LAST);
  assign cnt_zero_s = (cnt_q == '0);
  assign cnt_val    = cnt_q;

  pbu_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cont     (cont),
    .match    (match_s),
    .last_bit (last_bit_s),
    .cnt_zero (cnt_zero_s),
    .ctl      (ctl_s),
    .ready    (ready),
    .busy     (busy),
    .det      (det),
    .w_out    (w_out),
    .done     (done)
  );

  // Datapath next-state: pattern history, fill, bit counter, payload, counter
  always_comb begin
    pat_d  = pat_q;
    fill_d = fill_q;
    bit_d  = bit_q;
    pay_d  = pay_q;
    cnt_d  = cnt_q;

    if (ctl_s.pat_clr) begin
      pat_d  = '0;
      fill_d = '0;
    end else if (ctl_s.pat_shift) begin
      pat_d = window_s[PAT_W-2:0];
      if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1'b1);
      else                    fill_d = fill_q;
    end else begin
      pat_d = pat_q;
    end

    if (ctl_s.cap_clr) begin
      bit_d = '0;
      pay_d = '0;
    end else if (ctl_s.cap_shift) begin
      pay_d = (pay_q << 1) | DATA_W'(ser_in);
      if (last_bit_s) bit_d = '0;
      else            bit_d = bit_q + BIT_W'(1'b1);
    end else begin
      pay_d = pay_q;
    end

    if (ctl_s.cnt_clr)       cnt_d = '0;
    else if (ctl_s.cnt_load) cnt_d = pay_q;
    else if (ctl_s.cnt_dec)  cnt_d = cnt_q - DATA_W'(1'b1);
    else                     cnt_d = cnt_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      fill_q <= '0;
      bit_q  <= '0;
      pay_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      fill_q <= fill_d;
      bit_q  <= bit_d;
      pay_q  <= pay_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pattern_burst_unit.sv
// Scenario bench for pattern_burst_unit: expected burst lengths are queued when
// a payload is driven and consumed when the DUT signals done.
module tb_pattern_burst_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic       ser_in = 1'b0;
  logic       ready, busy, det, w_out, done;
  logic [7:0] cnt_val;
  logic       ready2, busy2, det2, w_out2, done2;
  logic [7:0] cnt_val2;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int busy_low_cnt = 0;

  pattern_burst_unit dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont), .ser_in(ser_in),
    .ready(ready), .busy(busy), .det(det), .w_out(w_out), .done(done), .cnt_val(cnt_val)
  );

  pattern_burst_unit #(.PATTERN(4'b0001)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont), .ser_in(ser_in),
    .ready(ready2), .busy(busy2), .det(det2), .w_out(w_out2), .done(done2), .cnt_val(cnt_val2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!busy) busy_low_cnt <= busy_low_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; abort = 1'b0; cont = 1'b0; ser_in = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic drive_bits(input logic [15:0] bits, input int n, output int pos, output int pos2);
    pos = 0; pos2 = 0;
    for (int i = 0; i < n; i++) begin
      ser_in = bits[n-1-i];
      @(negedge clk);
      if (det && pos == 0) pos = i + 1;
      if (det2 && pos2 == 0) pos2 = i + 1;
      tick();
    end
    ser_in = 1'b0;
  endtask

  // Starts on the LOAD cycle; didx is the 1-based cycle index of done (0 on timeout).
  task automatic wait_done(output int wcnt, output int didx, output int nz);
    wcnt = 0; didx = 0; nz = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (w_out) wcnt++;
      if (cnt_val != 8'd0) nz++;
      if (done) begin
        didx = k;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if ({det, w_out, done} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b exp 000", {det, w_out, done}); end
    n_checks++; if (cnt_val !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cnt_val); end
    n_checks++; if ({ready2, busy2, det2, w_out2, done2, cnt_val2} !== {5'b10000, 8'd0}) begin
      n_fail++; $display("FAIL reset_dut2 got %b exp 1000000000000", {ready2, busy2, det2, w_out2, done2, cnt_val2});
    end
    tick();
  endtask

  task automatic test_basic();
    int p, p2, wc, di, nz, e;
    launch();
    drive_bits(16'b1101, 4, p, p2);
    n_checks++; if (p !== 4) begin n_fail++; $display("FAIL basic_det_pos got %0d exp 4", p); end
    exp_q.push_back(3);
    drive_bits(16'h0003, 8, p, p2);
    n_checks++; if (p !== 0) begin n_fail++; $display("FAIL basic_det_in_payload got %0d exp 0", p); end
    wait_done(wc, di, nz);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_checks++; if (wc !== e) begin n_fail++; $display("FAIL basic_wout_len got %0d exp %0d", wc, e); end
    n_checks++; if (di !== e + 2) begin n_fail++; $display("FAIL basic_done_cycle got %0d exp %0d", di, e + 2); end
    @(negedge clk);
    n_checks++; if ({ready, done} !== 2'b10) begin n_fail++; $display("FAIL basic_ready_after got %b exp 10", {ready, done}); end
    tick();
  endtask

  task automatic test_zero();
    int p, p2, wc, di, nz, e;
    launch();
    drive_bits(16'b1101, 4, p, p2);
    exp_q.push_back(0);
    drive_bits(16'h0000, 8, p, p2);
    wait_done(wc, di, nz);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_checks++; if (wc !== e) begin n_fail++; $display("FAIL zero_wout_len got %0d exp %0d", wc, e); end
    n_checks++; if (di !== e + 2) begin n_fail++; $display("FAIL zero_done_cycle got %0d exp %0d", di, e + 2); end
    n_checks++; if (nz !== 0) begin n_fail++; $display("FAIL zero_cnt_nonzero got %0d cycles exp 0", nz); end
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_after got %b exp 1", ready); end
    tick();
  endtask

  task automatic test_overlap();
    int p, p2;
    do_reset();
    launch();
    drive_bits(16'b11101, 5, p, p2);
    n_checks++; if (p !== 5) begin n_fail++; $display("FAIL overlap_det_pos got %0d exp 5", p); end
    do_reset();
    launch();
    drive_bits(16'b10001, 5, p, p2);
    n_checks++; if (p2 !== 5) begin n_fail++; $display("FAIL fill_gate_lead1 got %0d exp 5", p2); end
    do_reset();
    launch();
    drive_bits(16'b0010001, 7, p, p2);
    n_checks++; if (p2 !== 7) begin n_fail++; $display("FAIL fill_gate_lead0 got %0d exp 7", p2); end
    do_reset();
  endtask

  task automatic test_abort();
    int p, p2, wc, di, nz, e;
    launch();
    drive_bits(16'b1101, 4, p, p2);
    drive_bits(16'b101, 3, p, p2);
    abort = 1'b1;
    @(negedge clk);
    n_checks++; if ({det, w_out, done} !== 3'b000) begin n_fail++; $display("FAIL abort_cap_pulses got %b exp 000", {det, w_out, done}); end
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_checks++; if ({ready, busy, done, cnt_val} !== {3'b100, 8'd0}) begin
      n_fail++; $display("FAIL abort_cap_idle got %b exp 10000000000", {ready, busy, done, cnt_val});
    end
    tick();
    launch();
    drive_bits(16'b1101, 4, p, p2);
    drive_bits(16'h0010, 8, p, p2);
    tick();
    abort = 1'b1;
    @(negedge clk);
    n_checks++; if (cnt_val !== 8'd16) begin n_fail++; $display("FAIL abort_count_load got %0d exp 16", cnt_val); end
    n_checks++; if ({w_out, done} !== 2'b00) begin n_fail++; $display("FAIL abort_count_pulses got %b exp 00", {w_out, done}); end
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_checks++; if ({ready, cnt_val} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL abort_count_idle got %b exp 100000000", {ready, cnt_val}); end
    tick();
    launch();
    drive_bits(16'b1101, 4, p, p2);
    n_checks++; if (p !== 4) begin n_fail++; $display("FAIL abort_restart_det got %0d exp 4", p); end
    exp_q.push_back(2);
    drive_bits(16'h0002, 8, p, p2);
    wait_done(wc, di, nz);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_checks++; if (wc !== e) begin n_fail++; $display("FAIL abort_restart_len got %0d exp %0d", wc, e); end
    n_checks++; if (di !== e + 2) begin n_fail++; $display("FAIL abort_restart_done got %0d exp %0d", di, e + 2); end
  endtask

  task automatic test_back_to_back();
    int p, p2, wc, di, nz, e, b0;
    do_reset();
    cont = 1'b1;
    launch();
    b0 = busy_low_cnt;
    drive_bits(16'b1101, 4, p, p2);
    exp_q.push_back(2);
    drive_bits(16'h0002, 8, p, p2);
    wait_done(wc, di, nz);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_checks++; if (wc !== e) begin n_fail++; $display("FAIL cont_f1_len got %0d exp %0d", wc, e); end
    n_checks++; if (di !== e + 2) begin n_fail++; $display("FAIL cont_f1_done got %0d exp %0d", di, e + 2); end
    drive_bits(16'b1101, 4, p, p2);
    n_checks++; if (p !== 4) begin n_fail++; $display("FAIL cont_f2_det got %0d exp 4", p); end
    exp_q.push_back(1);
    drive_bits(16'h0001, 8, p, p2);
    wait_done(wc, di, nz);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    n_checks++; if (wc !== e) begin n_fail++; $display("FAIL cont_f2_len got %0d exp %0d", wc, e); end
    n_checks++; if (di !== e + 2) begin n_fail++; $display("FAIL cont_f2_done got %0d exp %0d", di, e + 2); end
    n_checks++; if (busy_low_cnt !== b0) begin n_fail++; $display("FAIL cont_busy_low got %0d exp %0d", busy_low_cnt, b0); end
    cont = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_held_start_reset();
    int p, p2;
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ser_in = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if ({ready, busy, det} !== 3'b010) begin n_fail++; $display("FAIL held_init_%0d got %b exp 010", i, {ready, busy, det}); end
      end
      tick();
    end
    start = 1'b0;
    ser_in = 1'b0;
    tick();
    drive_bits(16'b1101, 4, p, p2);
    n_checks++; if (p !== 4) begin n_fail++; $display("FAIL held_det_pos got %0d exp 4", p); end
    drive_bits(16'h0005, 8, p, p2);
    tick();
    @(negedge clk);
    n_checks++; if ({w_out, cnt_val} !== {1'b1, 8'd5}) begin n_fail++; $display("FAIL midburst_cnt got %b exp 100000101", {w_out, cnt_val}); end
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if ({ready, busy, det, w_out, done, cnt_val} !== {5'b10000, 8'd0}) begin
      n_fail++; $display("FAIL midburst_reset got %b exp 1000000000000", {ready, busy, det, w_out, done, cnt_val});
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overlap();
    test_abort();
    test_back_to_back();
    test_held_start_reset();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
